// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/wait_for_mem memory port bundle
//
// Purpose: one memory access port. The master side raises a one-cycle req
//   with addr/wdata/access_type/access_size; the slave side answers with
//   wait_for_mem (busy) and rdata.
// Ports (signals):
//   req          master->slave  one-cycle request pulse
//   addr         master->slave  access address
//   wdata        master->slave  write data
//   access_type  master->slave  0 = read, 1 = write
//   access_size  master->slave  0 = 32-bit, 1 = 16-bit, 2 = 8-bit
//   wait_for_mem slave->master  access pending or in flight
//   rdata        slave->master  read data
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  access_type;
  logic [1:0]            access_size;
  logic                  wait_for_mem;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, addr, wdata, access_type, access_size,
    input  wait_for_mem, rdata
  );

  modport slave (
    input  req, addr, wdata, access_type, access_size,
    output wait_for_mem, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin/fixed-priority MainMem arbiter
//
// Purpose: shares one MainMem port between port 0 (CPU) and port 1
//   (DMA/debug loader). Requests are latched per port, arbitrated and
//   serialised onto the MainMem req/wait_for_mem handshake.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   p0         slave  port 0 requester interface
//   p1         slave  port 1 requester interface
//   mem        master MainMem interface
//   proto_err  out  sticky: a req arrived while that port was still busy
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  mem_arbiter_if.master mem,
  output logic          proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Per-port views of the two requester interfaces so the accept logic
  // can be written once as a loop.
  logic [1:0]            req_in;
  logic [ADDR_WIDTH-1:0] addr_in  [2];
  logic [DATA_WIDTH-1:0] wdata_in [2];
  logic [1:0]            type_in;
  logic [1:0]            size_in  [2];

  assign req_in      = {p1.req, p0.req};
  assign addr_in[0]  = p0.addr;
  assign addr_in[1]  = p1.addr;
  assign wdata_in[0] = p0.wdata;
  assign wdata_in[1] = p1.wdata;
  assign type_in     = {p1.access_type, p0.access_type};
  assign size_in[0]  = p0.access_size;
  assign size_in[1]  = p1.access_size;

  // Latched request fields; pend_q doubles as the port's wait output.
  logic [1:0]            pend_q;
  logic [ADDR_WIDTH-1:0] addr_q  [2];
  logic [DATA_WIDTH-1:0] wdata_q [2];
  logic [1:0]            type_q;
  logic [1:0]            size_q  [2];
  logic [DATA_WIDTH-1:0] rdata_q [2];

  state_t                state_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_type_q;
  logic [1:0]            mem_size_q;
  logic                  pick;

  assign p0.wait_for_mem = pend_q[0];
  assign p1.wait_for_mem = pend_q[1];
  assign p0.rdata        = rdata_q[0];
  assign p1.rdata        = rdata_q[1];

  assign mem.req         = mem_req_q;
  assign mem.addr        = mem_addr_q;
  assign mem.wdata       = mem_wdata_q;
  assign mem.access_type = mem_type_q;
  assign mem.access_size = mem_size_q;

  // Winner among pending ports. On a tie, round-robin favours the port that
  // was not granted last; fixed priority always favours port 0.
  always_comb begin
    pick = 1'b0;
    if (pend_q[0] && pend_q[1]) begin
      pick = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
    end else if (pend_q[1]) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= 2'b00;
      type_q       <= 2'b00;
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_type_q   <= 1'b0;
      mem_size_q   <= 2'b00;
      proto_err    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        size_q[i]  <= 2'b00;
        rdata_q[i] <= '0;
      end
    end else begin
      // Accept: a port can only hold one access. A req while busy is a
      // requester protocol violation; its fields are discarded.
      for (int i = 0; i < 2; i++) begin
        if (req_in[i]) begin
          if (pend_q[i]) begin
            proto_err <= 1'b1;
          end else begin
            pend_q[i]  <= 1'b1;
            addr_q[i]  <= addr_in[i];
            wdata_q[i] <= wdata_in[i];
            type_q[i]  <= type_in[i];
            size_q[i]  <= size_in[i];
          end
        end
      end

      case (state_q)
        ST_IDLE: begin
          mem_req_q <= 1'b0;
          if (pend_q != 2'b00) begin
            grant_q      <= pick;
            last_grant_q <= pick;
            mem_addr_q   <= addr_q[pick];
            mem_wdata_q  <= wdata_q[pick];
            mem_type_q   <= type_q[pick];
            mem_size_q   <= size_q[pick];
            mem_req_q    <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_WAIT;
        end

        ST_WAIT: begin
          mem_req_q <= 1'b0;
          // The granted port is pending, so its accept branch above cannot
          // fire in the same cycle; clearing pend here never races it.
          if (!mem.wait_for_mem) begin
            if (!mem_type_q) begin
              rdata_q[grant_q] <= mem.rdata;
            end
            pend_q[grant_q] <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end

        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) pa0 ();
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) pa1 ();
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ma  ();
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) pb0 ();
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) pb1 ();
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mb  ();

  logic perr_a, perr_b;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1'b0)) dut_a (
    .clk(clk), .rst(rst), .p0(pa0), .p1(pa1), .mem(ma), .proto_err(perr_a));

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1'b1)) dut_b (
    .clk(clk), .rst(rst), .p0(pb0), .p1(pb1), .mem(mb), .proto_err(perr_b));

  // The fixed-priority instance sees exactly the same requester stimulus.
  assign pb0.req = pa0.req;
  assign pb0.addr = pa0.addr;
  assign pb0.wdata = pa0.wdata;
  assign pb0.access_type = pa0.access_type;
  assign pb0.access_size = pa0.access_size;
  assign pb1.req = pa1.req;
  assign pb1.addr = pa1.addr;
  assign pb1.wdata = pa1.wdata;
  assign pb1.access_type = pa1.access_type;
  assign pb1.access_size = pa1.access_size;

  // MainMem models: wait_for_mem high for n_waits cycles after the req edge.
  int n_waits = 1;
  logic use_fixed = 1'b0;
  logic [31:0] fixed_rd = 32'h0;
  assign ma.rdata = use_fixed ? fixed_rd : (ma.addr ^ 32'hC0DE0000);
  assign mb.rdata = use_fixed ? fixed_rd : (mb.addr ^ 32'hC0DE0000);

  int cnt_a, cnt_b;
  int n_log_a = 0, n_log_b = 0;
  logic [31:0] log_a [0:63];
  logic [31:0] log_b [0:63];
  logic [31:0] cap_addr, cap_wdata;
  logic cap_type;
  logic [1:0] cap_size;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma.wait_for_mem <= 1'b0;
      cnt_a <= 0;
    end else if (ma.req) begin
      ma.wait_for_mem <= (n_waits != 0);
      cnt_a <= n_waits;
      if (n_log_a < 64) log_a[n_log_a] <= ma.addr;
      n_log_a <= n_log_a + 1;
      cap_addr <= ma.addr;
      cap_wdata <= ma.wdata;
      cap_type <= ma.access_type;
      cap_size <= ma.access_size;
    end else if (cnt_a > 1) begin
      cnt_a <= cnt_a - 1;
    end else if (cnt_a == 1) begin
      cnt_a <= 0;
      ma.wait_for_mem <= 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb.wait_for_mem <= 1'b0;
      cnt_b <= 0;
    end else if (mb.req) begin
      mb.wait_for_mem <= (n_waits != 0);
      cnt_b <= n_waits;
      if (n_log_b < 64) log_b[n_log_b] <= mb.addr;
      n_log_b <= n_log_b + 1;
    end else if (cnt_b > 1) begin
      cnt_b <= cnt_b - 1;
    end else if (cnt_b == 1) begin
      cnt_b <= 0;
      mb.wait_for_mem <= 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives req for one cycle and returns at the next negedge.
  task automatic issue(input int port, input logic typ, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      pa0.req = 1'b1; pa0.access_type = typ; pa0.access_size = size;
      pa0.addr = addr; pa0.wdata = wdata;
    end else begin
      pa1.req = 1'b1; pa1.access_type = typ; pa1.access_size = size;
      pa1.addr = addr; pa1.wdata = wdata;
    end
    @(negedge clk);
    pa0.req = 1'b0;
    pa1.req = 1'b0;
  endtask

  task automatic issue_both(input logic [31:0] a0, input logic [31:0] a1);
    pa0.req = 1'b1; pa0.access_type = 1'b0; pa0.access_size = 2'd0; pa0.addr = a0; pa0.wdata = 32'h0;
    pa1.req = 1'b1; pa1.access_type = 1'b0; pa1.access_size = 2'd0; pa1.addr = a1; pa1.wdata = 32'h0;
    @(negedge clk);
    pa0.req = 1'b0;
    pa1.req = 1'b0;
  endtask

  // Counts negedges on which the port's wait (DUT A) is high.
  task automatic wait_idle(input int port, output int cycles);
    cycles = 0;
    while (((port == 0) ? pa0.wait_for_mem : pa1.wait_for_mem) && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    check("wait_idle timeout", (cycles >= 200) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic wait_all_idle();
    int n;
    n = 0;
    while ((pa0.wait_for_mem || pa1.wait_for_mem || pb0.wait_for_mem || pb1.wait_for_mem) && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("wait_all_idle timeout", (n >= 300) ? 32'd1 : 32'd0, 32'd0);
  endtask

  typedef struct {
    int          port;
    logic        typ;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, base_a, base_b;

    vecs[0] = '{0, 1'b0, 2'd0, 32'h0000_0400, 32'h0000_0000, 0, 32'hC0DE_0400, 3};
    vecs[1] = '{1, 1'b0, 2'd1, 32'h0000_1234, 32'h0000_0000, 1, 32'hC0DE_1234, 4};
    vecs[2] = '{1, 1'b1, 2'd2, 32'h0000_2003, 32'h0000_0055, 1, 32'hC0DE_1234, 4};
    vecs[3] = '{0, 1'b1, 2'd0, 32'h0000_0800, 32'hCAFE_F00D, 3, 32'hC0DE_0400, 6};
    vecs[4] = '{0, 1'b0, 2'd2, 32'hFFFF_FFFC, 32'h0000_0000, 2, 32'h3F21_FFFC, 5};
    vecs[5] = '{1, 1'b0, 2'd0, 32'h1234_5678, 32'h0000_0000, 0, 32'hD2EA_5678, 3};

    pa0.req = 1'b0; pa0.addr = '0; pa0.wdata = '0; pa0.access_type = 1'b0; pa0.access_size = 2'd0;
    pa1.req = 1'b0; pa1.addr = '0; pa1.wdata = '0; pa1.access_type = 1'b0; pa1.access_size = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("reset p0_wait", {31'b0, pa0.wait_for_mem}, 32'd0);
    check("reset p1_wait", {31'b0, pa1.wait_for_mem}, 32'd0);
    check("reset mem_req", {31'b0, ma.req}, 32'd0);
    check("reset proto_err", {31'b0, perr_a}, 32'd0);
    check("reset p0_rdata", pa0.rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single read, two waits: mem_req at T+2, wait high T+1..T+5.
    use_fixed = 1'b1; fixed_rd = 32'hDEADBEEF; n_waits = 2;
    issue(0, 1'b0, 2'd0, 32'h0000_0100, 32'h0);
    check("t1 mem_req early", {31'b0, ma.req}, 32'd0);
    check("t1 p0_wait T+1", {31'b0, pa0.wait_for_mem}, 32'd1);
    @(negedge clk);
    check("t1 mem_req T+2", {31'b0, ma.req}, 32'd1);
    check("t1 mem_addr", ma.addr, 32'h0000_0100);
    wait_idle(0, lat);
    check("t1 latency", lat + 1, 32'd5);
    check("t1 p0_rdata", pa0.rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("t1 mem_req after", {31'b0, ma.req}, 32'd0);
    use_fixed = 1'b0;

    // Reset so both instances start with last_grant = 1.
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    n_waits = 1;

    base_a = n_log_a; base_b = n_log_b;
    issue_both(32'h0000_0100, 32'h0000_0200);
    wait_all_idle();
    check("tie1 rr first", log_a[base_a], 32'h0000_0100);
    check("tie1 rr second", log_a[base_a + 1], 32'h0000_0200);
    check("tie1 fix first", log_b[base_b], 32'h0000_0100);
    check("tie1 p0_rdata", pa0.rdata, 32'hC0DE_0100);
    check("tie1 p1_rdata", pa1.rdata, 32'hC0DE_0200);

    // p0 served alone, so round-robin now favours p1 on the next tie.
    issue(0, 1'b0, 2'd0, 32'h0000_0300, 32'h0);
    wait_all_idle();
    base_a = n_log_a; base_b = n_log_b;
    issue_both(32'h0000_0100, 32'h0000_0200);
    wait_all_idle();
    check("tie2 rr first", log_a[base_a], 32'h0000_0200);
    check("tie2 rr second", log_a[base_a + 1], 32'h0000_0100);
    check("tie2 fix first", log_b[base_b], 32'h0000_0100);
    check("tie2 fix second", log_b[base_b + 1], 32'h0000_0200);

    // Table: each request issued in the first cycle its port's wait is low.
    for (int i = 0; i < 6; i++) begin
      n_waits = vecs[i].waits;
      issue(vecs[i].port, vecs[i].typ, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      wait_idle(vecs[i].port, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d mem_addr", i), cap_addr, vecs[i].addr);
      check($sformatf("vec%0d mem_wdata", i), cap_wdata, vecs[i].wdata);
      check($sformatf("vec%0d mem_type", i), {31'b0, cap_type}, {31'b0, vecs[i].typ});
      check($sformatf("vec%0d mem_size", i), {30'b0, cap_size}, {30'b0, vecs[i].size});
      check($sformatf("vec%0d rdata", i),
            (vecs[i].port == 0) ? pa0.rdata : pa1.rdata, vecs[i].exp_rdata);
    end

    // Other port requests while the first access is in WAIT.
    n_waits = 4;
    base_a = n_log_a;
    issue(0, 1'b0, 2'd0, 32'h0000_0900, 32'h0);
    repeat (2) @(negedge clk);
    issue(1, 1'b0, 2'd0, 32'h0000_0A00, 32'h0);
    wait_all_idle();
    check("during wait first", log_a[base_a], 32'h0000_0900);
    check("during wait second", log_a[base_a + 1], 32'h0000_0A00);
    check("during wait p1_rdata", pa1.rdata, 32'hC0DE_0A00);

    // Protocol violation: second p0 req while p0 is busy is dropped.
    check("proto_err before", {31'b0, perr_a}, 32'd0);
    base_a = n_log_a;
    issue(0, 1'b0, 2'd0, 32'h0000_0500, 32'h0);
    issue(0, 1'b1, 2'd0, 32'h0000_0999, 32'h1111_1111);
    wait_all_idle();
    repeat (3) @(negedge clk);
    check("proto_err set", {31'b0, perr_a}, 32'd1);
    check("proto_err accesses", n_log_a - base_a, 32'd1);
    check("proto_err addr", log_a[base_a], 32'h0000_0500);
    check("proto_err p0_rdata", pa0.rdata, 32'hC0DE_0500);

    // Reset while an access is in WAIT.
    n_waits = 10;
    issue(1, 1'b0, 2'd0, 32'h0000_0600, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst p1_wait", {31'b0, pa1.wait_for_mem}, 32'd0);
    check("rst p1_rdata", pa1.rdata, 32'd0);
    check("rst p0_rdata", pa0.rdata, 32'd0);
    check("rst mem_req", {31'b0, ma.req}, 32'd0);
    check("rst mem_addr", ma.addr, 32'd0);
    check("rst proto_err", {31'b0, perr_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_waits = 1;
    issue(1, 1'b0, 2'd0, 32'h0000_0700, 32'h0);
    wait_idle(1, lat);
    check("post rst latency", lat, 32'd4);
    check("post rst p1_rdata", pa1.rdata, 32'hC0DE_0700);
    check("post rst p0_wait", {31'b0, pa0.wait_for_mem}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
